// File: rtl/motor_pwm_driver.sv
// Slew-limited PWM motor driver: ramps the applied duty toward the commanded speed
// once per PWM period, and latches power-stage faults until explicitly cleared.
module motor_pwm_driver #(
  parameter int PRESCALE  = 4,
  parameter int RAMP_STEP = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] speed,
  input  logic       fault,
  input  logic       fault_clr,
  output logic       pwm_out,
  output logic [7:0] duty,
  output logic       period_start,
  output logic       busy,
  output logic       fault_flag,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RAMP  = 2'd1,
    S_RUN   = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [8:0]    STEP9      = 9'(RAMP_STEP);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    duty_q, duty_d;
  logic          pwm_q, pwm_d;
  logic          period_start_q, period_start_d;
  logic          busy_q, busy_d;
  logic          fault_flag_q, fault_flag_d;

  logic          active_q, active_d, tick, boundary;
  logic [7:0]    stepped;

  // 9-bit arithmetic so the step saturates at the target instead of wrapping.
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    logic [8:0] up;
    logic [8:0] down;
    up   = {1'b0, cur} + STEP9;
    down = {1'b0, cur} - STEP9;
    if (tgt > cur)
      return (up > {1'b0, tgt}) ? tgt : up[7:0];
    else if (tgt < cur)
      return (down[8] || (down < {1'b0, tgt})) ? tgt : down[7:0];
    else
      return cur;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first, so no path through the
    // case/if tree leaves a variable unassigned and infers a latch.
    active_q = (state_q == S_RAMP) || (state_q == S_RUN);
    tick     = active_q && (presc_q == PRESC_LAST);
    boundary = tick && (cnt_q == 8'hFF);
    stepped  = step_toward(duty_q, speed);

    presc_d  = '0;
    cnt_d    = '0;
    if (active_q) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
      cnt_d   = tick ? cnt_q + 8'd1 : cnt_q;
    end

    state_d = state_q;
    duty_d  = duty_q;
    if (fault) begin
      state_d = S_FAULT;
      duty_d  = 8'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          duty_d = 8'd0;
          if (en) state_d = S_RAMP;
        end
        S_RAMP: begin
          if (!en) begin
            state_d = S_IDLE;
            duty_d  = 8'd0;
          end else if (boundary) begin
            duty_d = stepped;
            if (stepped == speed) state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (!en) begin
            state_d = S_IDLE;
            duty_d  = 8'd0;
          end else if (boundary && (speed != duty_q)) begin
            state_d = S_RAMP;
            duty_d  = stepped;
          end
        end
        S_FAULT: begin
          duty_d = 8'd0;
          if (fault_clr) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Output stage looks at the next state so a fault or disable silences pwm on the same edge.
    active_d       = (state_d == S_RAMP) || (state_d == S_RUN);
    pwm_d          = active_d && (cnt_q < duty_q);
    period_start_d = boundary && active_d;
    busy_d         = (state_d == S_RAMP);
    fault_flag_d   = (state_d == S_FAULT);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      presc_q        <= '0;
      cnt_q          <= '0;
      duty_q         <= '0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
      busy_q         <= 1'b0;
      fault_flag_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      duty_q         <= duty_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      busy_q         <= busy_d;
      fault_flag_q   <= fault_flag_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign duty         = duty_q;
  assign period_start = period_start_q;
  assign busy         = busy_q;
  assign fault_flag   = fault_flag_q;
  assign state        = state_q;

endmodule

// File: doc/motor_pwm_driver.md
Name: motor_pwm_driver

Overview:
- Stage directly downstream of the speed controller: consumes its 8-bit speed value and drives the motor power stage.
- Ramps the active duty toward the commanded speed by a bounded step per PWM period (slew limiting).
- Produces a glitch-free PWM output with duty updated only at period boundaries.
- Latches external faults and forces the output low until an explicit clear.

Parameters:
- PRESCALE, 4, clocks per PWM counter tick (≥1).
- RAMP_STEP, 8, maximum duty change per PWM period (1–255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  drive enable; 0 forces IDLE.
- speed  input  8  commanded duty target from the speed controller (0–255).
- fault  input  1  power-stage fault, level.
- fault_clr  input  1  fault clear request, level.
- pwm_out  output  1  registered PWM drive.
- duty  output  8  currently applied duty.
- period_start  output  1  one-clk pulse on the PWM period boundary.
- busy  output  1  high while in RAMP.
- fault_flag  output  1  high while in FAULT.
- state  output  2  IDLE=0, RAMP=1, RUN=2, FAULT=3.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; duty, pwm_out, period_start, busy, fault_flag all 0; prescaler and PWM counter 0. Release is synchronous to the next clk edge.
- Prescaler:
  - Counts 0..PRESCALE-1 and issues a tick on PRESCALE-1.
  - PWM counter cnt (8-bit) increments on each tick and wraps 255→0.
  - Both counters are held at 0 in IDLE and FAULT.
- Period boundary:
  - Occurs on a tick with cnt==255. period_start is high for that single clk; it is only produced in RAMP or RUN.
  - On the same edge, speed is sampled as the target and duty is updated.
- pwm_out:
  - Registered: pwm_out <= (state is RAMP or RUN) && (cnt < duty), giving one clk latency from cnt.
  - duty=0 gives constant low; duty=255 gives 255 of 256 ticks high.
- Duty step at a boundary (saturating, no wrap):
  - target > duty: duty = min(duty+RAMP_STEP, target).
  - target < duty: duty = max(duty−RAMP_STEP, target).
  - Computed at 9-bit width to avoid overflow or underflow.
- FSM, priority fault > en:
  - Any state, fault=1: FAULT on the next edge. duty←0, pwm_out←0 on that edge.
  - IDLE: en=1 → RAMP. duty stays 0 until the first boundary.
  - RAMP: step at each boundary. If duty equals target after the step → RUN on the same edge. en=0 → IDLE on the next edge, duty←0.
  - RUN: at a boundary, if the sampled target ≠ duty → RAMP, and the step is applied on that same edge. en=0 → IDLE, duty←0.
  - FAULT: fault_clr=1 && fault=0 → IDLE. fault_clr is ignored while fault=1. en is ignored.
- Changes to speed between boundaries have no effect.
- busy = (state==RAMP). fault_flag = (state==FAULT). Both are registered.

Test Plan:
1. PRESCALE=1, RAMP_STEP=8; en=1, speed=40 → duty goes 8,16,24,32,40 at five consecutive period_start pulses (every 256 clks). busy=1 until duty=40, then state=RUN, busy=0.
2. From RUN at duty=40, speed=3 → duty goes 32,24,16,8,3 (saturates at target, no undershoot), then RUN.
3. Steady duty=64 → pwm_out high exactly 64 clks per 256-clk period. Change speed to 100 mid-period → no duty change until the next period_start.
4. Extremes: speed=255 → duty …240,248,255 (no wrap), pwm_out low exactly 1 tick per period. speed=0 → pwm_out never high.
5. RUN with duty=64, pulse fault for 3 clks with fault_clr=1 held → state=FAULT and pwm_out=0 on the next edge. Remains FAULT while fault=1. After fault drops, with fault_clr=1 → IDLE, duty=0, fault_flag=0.
6. Assert rst=0 mid-period with pwm_out=1 → pwm_out, duty and state are 0 without a clock edge. After release with en=1 → RAMP restarts from duty 0. Drop en mid-RAMP → IDLE next edge, duty=0.
